// File: rtl/sa_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_feeder_if
//  Description : Bus bundle between the tile buffers / PE-grid edge and the
//                systolic-array feeder.
//                master : tile-buffer side (drives start, weights, vectors)
//                slave  : feeder side (drives handshakes, grid-edge signals)
//  Signals     : start, cfg_len             - tile kick-off and vector count
//                wt_valid/wt_ready/wt_data  - weight row words (col c at c*bw)
//                act_valid/act_ready/act_data - activation vectors (row r at r*bw)
//                control_o, wt_o            - weight-chain drive to the top PEs
//                data_o, vec_valid_o        - skewed activations to the left PEs
//                busy, done                 - tile status
//  Revision    : 1.0 - initial release
// ============================================================================
interface sa_feeder_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int bit_width = 8,
    parameter int LEN_W     = 16
);
    logic                        start;
    logic [LEN_W-1:0]            cfg_len;
    logic                        wt_valid;
    logic                        wt_ready;
    logic [COLS*bit_width-1:0]   wt_data;
    logic                        act_valid;
    logic                        act_ready;
    logic [ROWS*bit_width-1:0]   act_data;
    logic                        control_o;
    logic [COLS*bit_width-1:0]   wt_o;
    logic [ROWS*bit_width-1:0]   data_o;
    logic [ROWS-1:0]             vec_valid_o;
    logic                        busy;
    logic                        done;

    modport master (
        output start, cfg_len, wt_valid, wt_data, act_valid, act_data,
        input  wt_ready, act_ready, control_o, wt_o, data_o, vec_valid_o, busy, done
    );

    modport slave (
        input  start, cfg_len, wt_valid, wt_data, act_valid, act_data,
        output wt_ready, act_ready, control_o, wt_o, data_o, vec_valid_o, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sa_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sa_feeder
//  Description : Front end of a column-stationary systolic array. Shifts a
//                ROWS-deep weight tile down the PE weight chain (control_o=1),
//                then streams activation vectors into the rows with a
//                diagonal skew (row r delayed r cycles), then drains the skew
//                lines and pulses done.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - sa_feeder_if.slave (handshakes, grid-edge outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_feeder #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int bit_width = 8,
    parameter int LEN_W     = 16
) (
    input wire         clk,
    input wire         rst,
    sa_feeder_if.slave bus
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0]    c_wt_last    = CW'(ROWS - 1);
    localparam logic [CW-1:0]    c_drain_last = CW'((ROWS > 1) ? ROWS - 2 : 0);
    localparam logic [CW-1:0]    c_cnt_one    = CW'(1);
    localparam logic [LEN_W-1:0] c_len_one    = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_zero   = '0;
    // A single-row array needs no drain cycles: done follows the last handshake.
    localparam bit               c_no_drain   = (ROWS == 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [LEN_W-1:0]          r_len;
    logic [CW-1:0]             r_wt_cnt;
    logic [LEN_W-1:0]          r_vec_cnt;
    logic [CW-1:0]             r_drain_cnt;
    logic                      r_control;
    logic [COLS*bit_width-1:0] r_wt_o;
    logic                      r_wt_ready;
    logic                      r_act_ready;
    logic                      r_busy;
    logic                      r_done;

    // Ready flags are registered and only high in their own state, so they
    // double as state qualifiers for the handshakes.
    logic w_wt_hs;
    logic w_act_hs;
    assign w_wt_hs  = r_wt_ready  & bus.wt_valid;
    assign w_act_hs = r_act_ready & bus.act_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_wt_cnt    <= '0;
            r_vec_cnt   <= '0;
            r_drain_cnt <= '0;
            r_control   <= 1'b0;
            r_wt_o      <= '0;
            r_wt_ready  <= 1'b0;
            r_act_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // The weight chain only shifts on handshake cycles; every other
            // cycle presents control=0 with a zero word.
            r_control <= 1'b0;
            r_wt_o    <= '0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_len      <= bus.cfg_len;
                        r_wt_cnt   <= '0;
                        r_vec_cnt  <= '0;
                        r_wt_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_wt_hs) begin
                        r_control <= 1'b1;
                        r_wt_o    <= bus.wt_data;
                        r_wt_cnt  <= r_wt_cnt + c_cnt_one;
                        if (r_wt_cnt == c_wt_last) begin
                            r_wt_ready  <= 1'b0;
                            r_drain_cnt <= '0;
                            if (r_len != c_len_zero) begin
                                r_act_ready <= 1'b1;
                                r_state     <= ST_STREAM;
                            end else if (c_no_drain) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_act_hs) begin
                        r_vec_cnt <= r_vec_cnt + c_len_one;
                        if (r_vec_cnt == r_len - c_len_one) begin
                            r_act_ready <= 1'b0;
                            r_drain_cnt <= '0;
                            if (c_no_drain) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // ROWS-1 cycles so the deepest lane of the last vector exits.
                    if (r_drain_cnt == c_drain_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_cnt_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Skew lines. Lane r has r delay stages plus the output register, so a
    // vector accepted in cycle t shows lane r on data_o at t+1+r. The lines
    // shift every cycle; outside STREAM nothing is accepted so only zero
    // bubbles are injected, which is what DRAIN needs and leaves the lines
    // empty by the time the FSM is back in IDLE.
    // ------------------------------------------------------------------
    logic [bit_width-1:0] r_lane_data [ROWS];
    logic                 r_lane_vld  [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [bit_width-1:0] w_in;
        assign w_in = w_act_hs ? bus.act_data[r*bit_width +: bit_width] : '0;

        if (r == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lane_data[r] <= '0;
                    r_lane_vld[r]  <= 1'b0;
                end else begin
                    r_lane_data[r] <= w_in;
                    r_lane_vld[r]  <= w_act_hs;
                end
            end
        end else begin : g_delay
            logic [bit_width-1:0] r_line [r];
            logic [r-1:0]         r_vline;
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) begin
                        r_line[k] <= '0;
                    end
                    r_vline        <= '0;
                    r_lane_data[r] <= '0;
                    r_lane_vld[r]  <= 1'b0;
                end else begin
                    r_line[0]  <= w_in;
                    r_vline[0] <= w_act_hs;
                    for (int k = 1; k < r; k++) begin
                        r_line[k]  <= r_line[k-1];
                        r_vline[k] <= r_vline[k-1];
                    end
                    r_lane_data[r] <= r_line[r-1];
                    r_lane_vld[r]  <= r_vline[r-1];
                end
            end
        end
    end

    logic [ROWS*bit_width-1:0] w_data_o;
    logic [ROWS-1:0]           w_vec_valid;
    always_comb begin
        w_data_o    = '0;
        w_vec_valid = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_data_o[r*bit_width +: bit_width] = r_lane_data[r];
            w_vec_valid[r]                     = r_lane_vld[r];
        end
    end

    assign bus.wt_ready    = r_wt_ready;
    assign bus.act_ready   = r_act_ready;
    assign bus.control_o   = r_control;
    assign bus.wt_o        = r_wt_o;
    assign bus.data_o      = w_data_o;
    assign bus.vec_valid_o = w_vec_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sa_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_feeder
//  Description : Self-checking bench for sa_feeder. Expected weight words and
//                skewed activation lanes are pushed to scoreboards, stamped
//                with the cycle they must appear, when the stimulus handshakes;
//                they are popped and compared when that cycle is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_feeder;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int BW    = 8;
    localparam int LEN_W = 16;
    localparam int WW    = COLS * BW;
    localparam int AW    = ROWS * BW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_feeder_if #(.ROWS(ROWS), .COLS(COLS), .bit_width(BW), .LEN_W(LEN_W)) bus ();

    sa_feeder #(.ROWS(ROWS), .COLS(COLS), .bit_width(BW), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {int cyc; logic [WW-1:0] val;} wexp_t;
    typedef struct {int cyc; int row; logic [BW-1:0] val;} aexp_t;
    wexp_t q_wt[$];
    aexp_t q_act[$];

    logic [WW-1:0] wt_words  [ROWS];
    logic [AW-1:0] act_words [8];

    function automatic logic [WW+AW+ROWS+4:0] all_outs();
        return {bus.control_o, bus.wt_o, bus.data_o, bus.vec_valid_o,
                bus.wt_ready, bus.act_ready, bus.busy, bus.done};
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.wt_valid  = 1'b0;
        bus.wt_data   = '0;
        bus.act_valid = 1'b0;
        bus.act_data  = '0;
    endtask

    // Runs one tile. Gaps drop valid for *_gap_n cycles once *_gap_at items
    // were accepted. start_mid pulses start once during DRAIN/STREAM (ignored).
    // chained: caller is inside the previous tile's done cycle.
    task automatic run_tile(input string name, input int len,
                            input int wgap_at, input int wgap_n,
                            input int agap_at, input int agap_n,
                            input bit start_mid, input bit chained);
        int k, t_start, t_done, nw, na, wg, ag;
        bit exp_wrdy, exp_ardy, exp_busy, exp_done, exp_c, exp_v, mid_sent, left;
        logic [WW-1:0] exp_w;
        logic [BW-1:0] exp_d;
        nw = 0; na = 0; wg = 0; ag = 0; t_done = -1; mid_sent = 1'b0;
        q_wt.delete();
        q_act.delete();
        if (!chained) begin
            @(posedge clk); #1;
        end
        bus.start   = 1'b1;
        bus.cfg_len = LEN_W'(len);
        t_start     = cyc;
        forever begin
            @(posedge clk); #1;
            k = cyc;
            bus.start = 1'b0;
            exp_wrdy  = (nw < ROWS);
            exp_ardy  = (nw == ROWS) && (na < len);
            bus.wt_valid = 1'b0;
            bus.wt_data  = WW'($urandom());
            if (nw < ROWS) begin
                if (nw == wgap_at && wg < wgap_n) wg++;
                else begin
                    bus.wt_valid = 1'b1;
                    bus.wt_data  = wt_words[nw];
                end
            end
            bus.act_valid = 1'b0;
            bus.act_data  = AW'($urandom());
            if (na < len) begin
                if (na == agap_at && ag < agap_n) ag++;
                else begin
                    bus.act_valid = 1'b1;
                    bus.act_data  = act_words[na];
                end
            end
            if (start_mid && nw == ROWS && !mid_sent) begin
                bus.start   = 1'b1;
                bus.cfg_len = LEN_W'(7);
                mid_sent    = 1'b1;
            end

            @(negedge clk);
            exp_busy = (t_done < 0) || (k < t_done);
            exp_done = (k == t_done);
            total++;
            if ({bus.wt_ready, bus.act_ready, bus.busy, bus.done} !==
                {exp_wrdy, exp_ardy, exp_busy, exp_done}) begin
                bad++;
                $display("FAIL %s status cyc=%0d got wrdy/ardy/busy/done=%b required=%b",
                         name, k - t_start,
                         {bus.wt_ready, bus.act_ready, bus.busy, bus.done},
                         {exp_wrdy, exp_ardy, exp_busy, exp_done});
            end

            exp_c = (q_wt.size() > 0) && (q_wt[0].cyc == k);
            exp_w = exp_c ? q_wt[0].val : '0;
            if (exp_c) void'(q_wt.pop_front());
            total++;
            if ({bus.control_o, bus.wt_o} !== {exp_c, exp_w}) begin
                bad++;
                $display("FAIL %s weight cyc=%0d got ctrl=%b wt=%h required ctrl=%b wt=%h",
                         name, k - t_start, bus.control_o, bus.wt_o, exp_c, exp_w);
            end

            for (int r = 0; r < ROWS; r++) begin
                exp_v = 1'b0;
                exp_d = '0;
                for (int i = 0; i < q_act.size(); i++) begin
                    if (q_act[i].cyc == k && q_act[i].row == r) begin
                        exp_v = 1'b1;
                        exp_d = q_act[i].val;
                        q_act.delete(i);
                        break;
                    end
                end
                total++;
                if ({bus.vec_valid_o[r], bus.data_o[r*BW +: BW]} !== {exp_v, exp_d}) begin
                    bad++;
                    $display("FAIL %s row%0d cyc=%0d got v=%b d=%h required v=%b d=%h",
                             name, r, k - t_start, bus.vec_valid_o[r],
                             bus.data_o[r*BW +: BW], exp_v, exp_d);
                end
            end

            if (bus.wt_valid && exp_wrdy) begin
                q_wt.push_back('{cyc: k + 1, val: bus.wt_data});
                nw++;
                if (nw == ROWS && len == 0) t_done = k + ROWS;
            end
            if (bus.act_valid && exp_ardy) begin
                for (int r = 0; r < ROWS; r++)
                    q_act.push_back('{cyc: k + 1 + r, row: r, val: bus.act_data[r*BW +: BW]});
                na++;
                if (na == len) t_done = k + ROWS;
            end

            if (k == t_done) break;
            if (k - t_start > 100) begin
                total++;
                bad++;
                $display("FAIL %s timeout got no done after %0d cycles required done", name, k - t_start);
                break;
            end
        end
        left  = (q_wt.size() != 0) || (q_act.size() != 0);
        total++;
        if (left) begin
            bad++;
            $display("FAIL %s leftover got wt=%0d act=%0d pending required 0",
                     name, q_wt.size(), q_act.size());
        end
        bus.wt_valid  = 1'b0;
        bus.act_valid = 1'b0;
    endtask

    task automatic test_reset();
        int s;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h required=0", all_outs());
        end
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.start    = 1'b1;
        bus.cfg_len  = LEN_W'(5);
        bus.wt_valid = 1'b1;
        bus.wt_data  = 32'hA5A5_A5A5;
        bus.act_valid = 1'b1;
        bus.act_data  = 32'h1122_3344;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.act_ready, bus.vec_valid_o[0], bus.data_o[7:0]} !== {1'b1, 1'b1, 1'b1, 8'h44}) begin
            bad++;
            $display("FAIL reset_pre_stream cyc=%0d got busy/ardy/v0/d0=%b/%b/%b/%h required 1/1/1/44",
                     cyc - s, bus.busy, bus.act_ready, bus.vec_valid_o[0], bus.data_o[7:0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (all_outs() !== '0) begin
                bad++;
                $display("FAIL reset_mid_stream cycle %0d got=%h required=0", i, all_outs());
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_weight_load();
        wt_words[0] = 32'h0403_0201; wt_words[1] = 32'h0807_0605;
        wt_words[2] = 32'h0C0B_0A09; wt_words[3] = 32'h100F_0E0D;
        act_words[0] = 32'h7F01_80FF;
        run_tile("weight_load", 1, -1, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_weight_stall();
        wt_words[0] = 32'h1111_1111; wt_words[1] = 32'h2222_2222;
        wt_words[2] = 32'h3333_3333; wt_words[3] = 32'h4444_4444;
        act_words[0] = 32'h0102_0304;
        run_tile("weight_stall", 1, 2, 2, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_skew();
        act_words[0] = 32'h0403_0201;
        act_words[1] = 32'h0807_0605;
        run_tile("skew", 2, -1, 0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_act_bubble();
        act_words[0] = 32'h0403_0201;
        act_words[1] = 32'h0807_0605;
        run_tile("act_bubble", 2, -1, 0, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        wt_words[0] = 32'hDEAD_BEEF; wt_words[1] = 32'hCAFE_F00D;
        wt_words[2] = 32'h8000_0001; wt_words[3] = 32'hFFFF_FFFF;
        run_tile("zero_len", 0, -1, 0, -1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        act_words[0] = 32'h80FF_7F01; act_words[1] = 32'hFE02_FD03;
        act_words[2] = 32'h0A0B_0C0D;
        run_tile("b2b_first", 3, 1, 1, 2, 2, 1'b0, 1'b0);
        wt_words[0] = 32'h0101_0101; wt_words[1] = 32'h0202_0202;
        wt_words[2] = 32'h0303_0303; wt_words[3] = 32'h0404_0404;
        act_words[0] = 32'h5566_7788; act_words[1] = 32'h99AA_BBCC;
        run_tile("b2b_second", 2, -1, 0, -1, 0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_weight_stall();
        test_skew();
        test_act_bubble();
        test_zero_len();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
